// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory req/ack port between fetch stage and memory
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] rdata;
    logic            ack;

    modport master (output req, output addr, input rdata, input ack);
    modport slave  (input req, input addr, output rdata, output ack);
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch with PC, req/ack imem port and IF/ID register
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      halt_i,
    input  logic            taken_branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    fetch_stage_if.master   imem,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic            if_id_valid_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] kill_addr_q, kill_addr_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    logic            if_valid_q, if_valid_d;

    logic            stall;
    logic [XLEN-1:0] target;
    logic            unused_bits;

    assign stall       = halt_i[4] | halt_i[3];
    assign target      = {branch_target_i[XLEN-1:2], 2'b00};
    assign unused_bits = ^{halt_i[2:0], branch_target_i[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ: begin
                if (taken_branch_i)   state_d = imem.ack ? S_REQ : S_DRAIN;
                else if (imem.ack)    state_d = stall ? S_HOLD : S_REQ;
            end
            S_HOLD: begin
                if (taken_branch_i || !stall) state_d = S_REQ;
            end
            S_DRAIN: begin
                // A fresh redirect keeps us draining only while the old response is still owed
                if (imem.ack)         state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem.req  = (state_q == S_REQ) || (state_q == S_DRAIN);
        imem.addr = (state_q == S_DRAIN) ? kill_addr_q : pc_q;
    end

    always_comb begin
        pc_d        = pc_q;
        kill_addr_d = kill_addr_q;
        buf_d       = buf_q;
        // ID consumes IF/ID every unstalled cycle; with nothing new a bubble takes its place
        if (stall) begin
            if_pc_d    = if_pc_q;
            if_instr_d = if_instr_q;
            if_valid_d = if_valid_q;
        end else begin
            if_pc_d    = '0;
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end

        if (taken_branch_i) begin
            pc_d       = target;
            buf_d      = NOP_INSTR;
            if_pc_d    = '0;
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
            if (state_q == S_REQ) begin
                kill_addr_d = pc_q;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem.ack) begin
                        if (stall) begin
                            buf_d = imem.rdata;
                        end else begin
                            if_pc_d    = pc_q;
                            if_instr_d = imem.rdata;
                            if_valid_d = 1'b1;
                            pc_d       = pc_q + XLEN'(4);
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if_pc_d    = pc_q;
                        if_instr_d = buf_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + XLEN'(4);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            kill_addr_q <= RESET_PC;
            buf_q       <= NOP_INSTR;
            if_pc_q     <= '0;
            if_instr_q  <= NOP_INSTR;
            if_valid_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            kill_addr_q <= kill_addr_d;
            buf_q       <= buf_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            if_valid_q  <= if_valid_d;
        end
    end

    assign if_id_pc_o    = if_pc_q;
    assign if_id_instr_o = if_instr_q;
    assign if_id_valid_o = if_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  halt;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;

    fetch_stage_if #(.XLEN(32)) imem ();

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .halt_i          (halt),
        .taken_branch_i  (br),
        .branch_target_i (tgt),
        .imem            (imem),
        .if_id_pc_o      (if_pc),
        .if_id_instr_o   (if_instr),
        .if_id_valid_o   (if_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic [31:0] d, input logic [4:0] h,
                         input logic b, input logic [31:0] t);
        imem.ack   = a;
        imem.rdata = d;
        halt       = h;
        br         = b;
        tgt        = t;
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h13579BDF;
    endfunction

    logic [31:0] stream_words [4];
    logic [31:0] exp_next, p_pc, p_instr, p_addr, r_tgt, r_data;
    logic        p_valid, p_req, r_ack, r_br;
    logic [4:0]  r_halt;
    int          deliveries;

    initial begin
        stream_words[0] = 32'h00100093;
        stream_words[1] = 32'h00200113;
        stream_words[2] = 32'h00300193;
        stream_words[3] = 32'h00400213;

        rst = 1'b1;
        drive(1'b0, 32'h0, 5'b0, 1'b0, 32'h0);
        tick();
        tick();
        chk("reset_req", 32'(imem.req), 32'd0);
        chk("reset_addr", imem.addr, 32'h0);
        chk("reset_valid", 32'(if_valid), 32'd0);
        chk("reset_instr", if_instr, NOP);
        chk("reset_pc", if_pc, 32'h0);

        rst = 1'b0;
        #1;
        chk("idle_req", 32'(imem.req), 32'd0);
        tick();
        chk("first_req", 32'(imem.req), 32'd1);
        chk("first_addr", imem.addr, 32'h0);
        chk("first_valid", 32'(if_valid), 32'd0);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, stream_words[i], 5'b0, 1'b0, 32'h0);
            tick();
            chk("stream_pc", if_pc, 32'(4 * i));
            chk("stream_instr", if_instr, stream_words[i]);
            chk("stream_valid", 32'(if_valid), 32'd1);
        end
        chk("stream_addr", imem.addr, 32'h10);

        drive(1'b1, 32'h00C00193, 5'b11100, 1'b0, 32'h0);
        tick();
        chk("stall_req", 32'(imem.req), 32'd0);
        chk("stall_hold_pc", if_pc, 32'hC);
        drive(1'b0, 32'h0, 5'b11100, 1'b0, 32'h0);
        tick();
        chk("stall_hold_instr", if_instr, 32'h00400213);
        chk("stall_hold_valid", 32'(if_valid), 32'd1);
        drive(1'b0, 32'h0, 5'b0, 1'b0, 32'h0);
        tick();
        chk("unstall_pc", if_pc, 32'h10);
        chk("unstall_instr", if_instr, 32'h00C00193);
        chk("unstall_addr", imem.addr, 32'h14);
        tick();
        chk("no_duplicate", 32'(if_valid), 32'd0);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, word_at(imem.addr), 5'b0, 1'b0, 32'h0);
            tick();
        end
        chk("pre_branch_addr", imem.addr, 32'h20);

        drive(1'b0, 32'h0, 5'b0, 1'b1, 32'h103);
        tick();
        chk("drain_addr", imem.addr, 32'h20);
        chk("drain_req", 32'(imem.req), 32'd1);
        chk("flush_valid", 32'(if_valid), 32'd0);
        drive(1'b1, 32'hDEADBEEF, 5'b0, 1'b0, 32'h0);
        tick();
        chk("redirect_addr", imem.addr, 32'h100);
        chk("late_ack_dropped", 32'(if_valid), 32'd0);
        drive(1'b1, 32'h00500293, 5'b0, 1'b0, 32'h0);
        tick();
        chk("target_pc", if_pc, 32'h100);
        chk("target_instr", if_instr, 32'h00500293);

        drive(1'b1, 32'h11111111, 5'b11100, 1'b0, 32'h0);
        tick();
        chk("hold_req", 32'(imem.req), 32'd0);
        drive(1'b0, 32'h0, 5'b11100, 1'b1, 32'h40);
        tick();
        chk("hold_br_addr", imem.addr, 32'h40);
        chk("hold_br_req", 32'(imem.req), 32'd1);
        chk("hold_br_instr", if_instr, NOP);
        chk("hold_br_valid", 32'(if_valid), 32'd0);
        chk("hold_br_pc", if_pc, 32'h0);
        drive(1'b1, 32'h22222222, 5'b0, 1'b0, 32'h0);
        tick();
        chk("buffer_dropped_pc", if_pc, 32'h40);
        chk("buffer_dropped_instr", if_instr, 32'h22222222);

        drive(1'b1, 32'h44444444, 5'b0, 1'b1, 32'hFFFFFFFF);
        tick();
        chk("ack_br_addr", imem.addr, 32'hFFFFFFFC);
        chk("ack_br_valid", 32'(if_valid), 32'd0);
        drive(1'b1, 32'h33333333, 5'b0, 1'b0, 32'h0);
        tick();
        chk("wrap_pc", if_pc, 32'hFFFFFFFC);
        chk("wrap_addr", imem.addr, 32'h0);

        drive(1'b0, 32'h0, 5'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_req", 32'(imem.req), 32'd0);
        chk("midrst_addr", imem.addr, 32'h0);
        chk("midrst_valid", 32'(if_valid), 32'd0);
        tick();
        rst = 1'b0;

        exp_next   = 32'h0;
        deliveries = 0;
        for (int n = 0; n < 3000; n++) begin
            p_req   = imem.req;
            p_addr  = imem.addr;
            p_pc    = if_pc;
            p_instr = if_instr;
            p_valid = if_valid;
            r_halt  = {(($urandom_range(3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00), 3'($urandom)};
            r_br    = ($urandom_range(19) == 0);
            r_tgt   = $urandom;
            r_ack   = p_req && ($urandom_range(1) == 1);
            r_data  = r_ack ? word_at(p_addr) : $urandom;
            drive(r_ack, r_data, r_halt, r_br, r_tgt);
            tick();
            if (r_br) begin
                chk("rnd_flush_valid", 32'(if_valid), 32'd0);
                chk("rnd_flush_instr", if_instr, NOP);
                exp_next = {r_tgt[31:2], 2'b00};
            end else if (r_halt[4] | r_halt[3]) begin
                chk("rnd_hold", {if_pc ^ p_pc ^ if_instr ^ p_instr, 31'b0, if_valid ^ p_valid} == '0 ? 32'd1 : 32'd0, 32'd1);
            end else if (if_valid) begin
                chk("rnd_order_pc", if_pc, exp_next);
                chk("rnd_instr", if_instr, word_at(if_pc));
                exp_next = exp_next + 32'd4;
                deliveries++;
            end
            if (p_req && !r_ack && !r_br) begin
                chk("rnd_addr_stable", imem.addr, p_addr);
            end
        end
        chk("rnd_progress", (deliveries > 100) ? 32'd1 : 32'd0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
